// File: rtl/mips_pkg.sv
// Shared definitions for the 8-bit MIPS jump-control path: interrupt FSM states,
// the RET opcode and the ISR vector used by jump control.
package mips_pkg;

  localparam int N_SRC = 4;
  localparam int ID_W  = 2;

  localparam logic [4:0] RET_OPC    = 5'b10000;
  localparam logic [7:0] ISR_VECTOR = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SERVICE
  } state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational 4-to-2 priority encoder; the lowest set index wins.
module irq_prio_enc
  import mips_pkg::*;
(
  input  logic [N_SRC-1:0] req_i,
  output logic [ID_W-1:0]  id_o,
  output logic             valid_o
);

  always_comb begin
    valid_o = |req_i;
    id_o    = '0;
    // Scan from the top down so the lowest requesting index is written last.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt source for jump control: edge-latched pending requests, mask,
// fixed priority and a single-cycle issue pulse held off until RET.
module interrupt_controller
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq,
  input  logic [19:0]      ins,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_in,
  output logic             interrupt,
  output logic [ID_W-1:0]  irq_id,
  output logic             in_service,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask
);

  state_e           state_q, state_d;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic             interrupt_q, interrupt_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic             in_service_q, in_service_d;

  logic [N_SRC-1:0] edges;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr;
  logic [ID_W-1:0]  winner;
  logic             win_valid;
  logic             is_ret;

  // Only the opcode field matters here; the operand bits belong to jump control.
  logic unused_ins;
  assign unused_ins = ^ins[14:0];

  assign edges    = irq & ~irq_q;
  assign eligible = pending_q & ~mask_q;
  assign is_ret   = (ins[19:15] == RET_OPC);

  irq_prio_enc u_prio (
    .req_i   (eligible),
    .id_o    (winner),
    .valid_o (win_valid)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    interrupt_d  = interrupt_q;
    irq_id_d     = irq_id_q;
    in_service_d = in_service_q;
    clr          = '0;

    unique case (state_q)
      IDLE: begin
        // ins[19] marks a jump/RET in the same stage; issuing then would collide with it.
        if (win_valid && !ins[19]) begin
          state_d      = ISSUE;
          irq_id_d     = winner;
          clr[winner]  = 1'b1;
          interrupt_d  = 1'b1;
          in_service_d = 1'b1;
        end
      end
      ISSUE: begin
        state_d     = SERVICE;
        interrupt_d = 1'b0;
      end
      SERVICE: begin
        if (is_ret) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new edge on the bit being cleared keeps it pending.
    pending_d = (pending_q & ~clr) | edges;
    mask_d    = mask_we ? mask_in : mask_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      irq_q        <= '1;
      pending_q    <= '0;
      mask_q       <= '1;
      interrupt_q  <= 1'b0;
      irq_id_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      interrupt_q  <= interrupt_d;
      irq_id_q     <= irq_id_d;
      in_service_q <= in_service_d;
    end
  end

  assign interrupt  = interrupt_q;
  assign irq_id     = irq_id_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;
  assign mask       = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: stimulus queues expected pulses
// (source ID and cycle), a negedge monitor pops and compares them.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq;
  logic [19:0] ins;
  logic        mask_we;
  logic [3:0]  mask_in;
  logic        interrupt;
  logic [1:0]  irq_id;
  logic        in_service;
  logic [3:0]  pending;
  logic [3:0]  mask;

  localparam logic [19:0] INS_RET = 20'h80000;
  localparam logic [19:0] INS_JNZ = 20'hF8000;

  typedef struct {
    logic [1:0] id;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  interrupt_controller dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .ins        (ins),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .interrupt  (interrupt),
    .irq_id     (irq_id),
    .in_service (in_service),
    .pending    (pending),
    .mask       (mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_irq(input logic [1:0] id, input int at_cyc);
    exp_t e;
    e.id  = id;
    e.cyc = at_cyc;
    sb.push_back(e);
  endtask

  // Monitor: every observed pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && interrupt === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'(irq_id), 32'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_id", 32'(irq_id), 32'(e.id));
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("pulse_in_service", 32'(in_service), 32'd1);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_interrupt"}, 32'(interrupt), 32'd0);
    check({tag, "_irq_id"}, 32'(irq_id), 32'd0);
    check({tag, "_in_service"}, 32'(in_service), 32'd0);
    check({tag, "_pending"}, 32'(pending), 32'd0);
    check({tag, "_mask"}, 32'(mask), 32'hF);
  endtask

  task automatic do_ret();
    ins = INS_RET;
    tick();
    ins = '0;
  endtask

  initial begin
    reset = 1'b1; irq = '0; ins = '0; mask_we = 1'b0; mask_in = '0;
    tick(2);
    check_reset_values("reset");
    reset = 1'b0;
    tick(2);

    // Single source: edge on irq[2] with everything unmasked.
    mask_we = 1'b1; mask_in = 4'h0;
    tick();
    mask_we = 1'b0;
    check("mask_write", 32'(mask), 32'h0);
    irq = 4'b0100;
    expect_irq(2'd2, cyc + 2);
    tick();
    check("t1_pending_set", 32'(pending), 32'b0100);
    check("t1_no_pulse_yet", 32'(interrupt), 32'd0);
    tick();
    check("t1_pending_clr", 32'(pending), 32'b0000);
    tick();
    check("t1_pulse_one_cycle", 32'(interrupt), 32'd0);
    check("t1_in_service", 32'(in_service), 32'd1);
    do_ret();
    check("t1_ret_in_service", 32'(in_service), 32'd0);
    irq = '0;
    tick(2);

    // Simultaneous edges on 3 and 1: 1 first, 3 two cycles after RET.
    irq = 4'b1010;
    expect_irq(2'd1, cyc + 2);
    tick();
    check("t2_pending_both", 32'(pending), 32'b1010);
    tick();
    check("t2_pending_left", 32'(pending), 32'b1000);
    tick();
    expect_irq(2'd3, cyc + 2);
    do_ret();
    check("t2_gap_idle", 32'(in_service), 32'd0);
    tick(2);
    check("t2_pending_empty", 32'(pending), 32'b0000);
    do_ret();
    irq = '0;
    tick(2);

    // Masked source stays pending, issues after unmask.
    mask_we = 1'b1; mask_in = 4'b0001;
    tick();
    mask_we = 1'b0;
    irq = 4'b0001;
    tick(3);
    check("t3_masked_pending", 32'(pending), 32'b0001);
    check("t3_masked_idle", 32'(in_service), 32'd0);
    mask_we = 1'b1; mask_in = 4'b0000;
    expect_irq(2'd0, cyc + 2);
    tick();
    mask_we = 1'b0;
    tick(2);
    check("t3_unmask_clr", 32'(pending), 32'b0000);
    do_ret();
    irq = '0;
    tick(2);

    // Three cycles of JNZ in the stage delay the issue by three cycles.
    irq = 4'b0100;
    ins = INS_JNZ;
    expect_irq(2'd2, cyc + 5);
    tick(4);
    check("t4_held_pending", 32'(pending), 32'b0100);
    check("t4_held_idle", 32'(in_service), 32'd0);
    ins = '0;
    tick(2);

    // Edge during SERVICE latches but does not pulse until RET.
    irq = 4'b0101;
    tick();
    check("t5_svc_pending", 32'(pending), 32'b0001);
    tick(2);
    check("t5_svc_no_pulse", 32'(interrupt), 32'd0);
    check("t5_svc_still", 32'(in_service), 32'd1);
    expect_irq(2'd0, cyc + 2);
    do_ret();
    check("t5_ret_drop", 32'(in_service), 32'd0);
    tick(2);

    // Reset in SERVICE with source 3 pending.
    irq = 4'b1101;
    tick();
    check("t6_pending_before", 32'(pending), 32'b1000);
    check("t6_in_service", 32'(in_service), 32'd1);
    reset = 1'b1;
    tick();
    check_reset_values("midreset");
    reset = 1'b0;
    tick(3);
    check("t6_no_edge_after_reset", 32'(pending), 32'b0000);
    irq = '0;

    // Drain: every queued pulse must have been observed within a bounded wait.
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Interrupt source side of the jump-control path in the 8-bit MIPS datapath. Collects up to four external request lines, latches rising edges as pending, applies a mask, and issues a single-cycle `interrupt` pulse toward the jump control block, which saves the return address and flags and vectors to 0xF0. After issuing, it holds off further interrupts until it decodes a RET instruction (ins[19:15] = 5'b10000), closing the initiate/return handshake. No nesting.

## Interface

Parameters:
- N_SRC, 4, number of request lines; fixed at 4 for this design because the ID is 2 bits.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high; clears all state on the next posedge.
- irq  in  4  request lines, synchronous to clk, rising-edge sensitive.
- ins  in  20  instruction currently in the jump-control stage; same word the jump control block decodes.
- mask_we  in  1  write strobe for the mask register.
- mask_in  in  4  new mask value; bit = 1 masks that source.
- interrupt  out  1  registered one-cycle pulse to jump control.
- irq_id  out  2  ID of the source issued or being serviced; valid while in_service = 1.
- in_service  out  1  high from the issue cycle until the RET is accepted.
- pending  out  4  latched requests not yet issued.
- mask  out  4  current mask.

## Operation

- Edge detect: irq_q <= irq every cycle. An edge on source i is irq[i]=1 with irq_q[i]=0. On an edge, pending[i] is set at that clock edge.
- Eligible set is `pending & ~mask`. The winner is the lowest index in the eligible set (source 0 has the highest priority).
- FSM states:
  - IDLE: go to ISSUE when the eligible set is nonzero and ins[19]=0. The ins[19] check stops an interrupt from colliding with a jump or RET in the same stage. On that transition, irq_id <= winner, pending[winner] is cleared, and interrupt <= 1.
  - ISSUE: lasts exactly one cycle with interrupt=1 and in_service=1. Unconditionally go to SERVICE; interrupt <= 0.
  - SERVICE: stay until ins[19:15]=5'b10000, then go to IDLE; in_service <= 0 on that edge.
- Edges keep latching into pending in every state. A masked pending bit stays set, and issues once it is unmasked.
- Simultaneous edge and clear on the same bit: the set wins, so the bit stays pending.
- mask_we: mask <= mask_in at the edge. The new mask affects eligibility from the next cycle. It does not affect an interrupt already issued.
- RET seen while in IDLE or ISSUE: ignored. It belongs to a plain subroutine or is spurious.
- Reset values: state=IDLE, interrupt=0, irq_id=0, in_service=0, pending=0, mask=4'hF (all masked), irq_q=4'hF. Setting irq_q to 4'hF means lines already high at reset do not create edges.
- Reset asserted mid-service: everything returns to the reset values, and pending requests are lost.

## Timing

- irq[i] is first sampled high at edge t. Then pending[i]=1 after edge t, interrupt=1 after edge t+1 (if eligible and ins[19]=0 during cycle t+1), and interrupt=0 after edge t+2.
- Minimum edge-to-interrupt latency is 2 cycles. Each cycle with ins[19]=1 in IDLE adds one cycle.
- RET is seen in SERVICE during cycle r. in_service falls after edge r. The earliest next interrupt is high after edge r+1, giving at least one idle cycle between services.
- Outputs are all registered. There is no combinational path from inputs to outputs.

## Structure

- Shared package (`mips_pkg`):
  - state enum {IDLE, ISSUE, SERVICE}
  - RET_OPC = 5'b10000
  - ISR_VECTOR = 8'hF0, shared with jump control
  - N_SRC
- Sub-module `irq_prio_enc`: combinational 4-to-2 priority encoder with a valid output.
- Top level: FSM, edge-detect register, pending register, and mask register.

## Test plan

- Reset, write mask=4'h0, pulse irq[2] 0→1 → pending=4'b0100 one cycle later; interrupt high for exactly 1 cycle, 2 cycles after the edge; irq_id=2; pending=0.
- Edges on irq[3] and irq[1] in the same cycle with mask=0 → irq[1] is issued first. After RET (ins=20'h80000), irq_id=3 is issued 2 cycles later.
- mask=4'b0001, edge on irq[0] → no interrupt and pending[0] stays 1. Write mask=0 → interrupt issued the next eligible cycle with irq_id=0.
- Eligible request while ins=20'hF8000 (JNZ) for 3 cycles → interrupt delayed 3 cycles, then a single pulse.
- In SERVICE, edge on irq[0] → pending[0]=1 and no pulse. RET → in_service=0, then interrupt again with irq_id=0.
- Assert reset in SERVICE with pending=4'b1000 → all outputs at reset values on the next cycle, and mask=4'hF.
